i2c_txn_sequencer: RTL and testbench
====================================

# i2c_txn_sequencer

Host-facing transaction sequencer placed directly upstream of the byte-level I2C master; it is the master's only driver. It accepts one register-style request per handshake (device address, 8-bit memory address, 1–4 bytes) and formats the master's command word. A read is executed as two master transactions: a memory-address write with zero data bytes, then a read. Read bytes are collected from the master's valid strobes, and one response per request is returned with status.

## Interface
- `TIMEOUT_CYC`, default 200000: max clk cycles per master transaction, counted from `m_start` assertion to `m_busy` fall.
- `MAX_RETRY`, default 3: extra attempts after an address NACK; used only with the retry option.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_rw` in 1: 0 = write, 1 = random read.
- `req_dev` in 7: 7-bit I2C device address.
- `req_mem` in 8: memory/register address.
- `req_len` in 3: byte count, legal 1..4.
- `req_wdata` in 32: write bytes; byte k is `[8k+7:8k]`, and byte 0 is sent first.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response accepted.
- `rsp_err` out 2: response status. 00 = OK, 01 = address NACK, 10 = timeout, 11 = illegal length.
- `rsp_rdata` out 32: read bytes, with the byte received k-th at `[8k+7:8k]`. Unfilled bytes are 0. The field is 0 for writes.
- `m_addr` out 7: command to master, device address.
- `m_rw` out 1: command to master, read/write.
- `m_data_w` out 40: command to master, packed memory address and data.
- `m_start` out 1: command to master, start request.
- `m_n_byte` out 4: command to master, data byte count.
- `m_data_out` in 8: read byte from master.
- `m_valid_out` in 1: one-cycle strobe, read byte valid.
- `m_busy` in 1: master transaction in progress.
- `m_erro_addr` in 1: one-cycle pulse, address NACK.

## Operation
**States:** IDLE, W_START, W_WAIT, R_START, R_WAIT, RESP.

**IDLE**
- `req_ready = 1` when `m_busy == 0`; otherwise 0.
- On `req_valid & req_ready`, latch all `req_*` fields and clear `rdata`, `err`, the byte index and the retry count.
- If `req_len` is 0 or >4, go to RESP with `err = 11`.
- Otherwise go to W_START.

**Write-phase command word**
- `m_addr = dev`, `m_rw = 0`.
- Write request: `m_data_w = {mem, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}`, `m_n_byte = len`.
- Read request: `m_data_w = {mem, 32'h0}`, `m_n_byte = 0`.

**W_START / R_START**
- Drive `m_start = 1` until `m_busy == 1` is sampled. Drop `m_start` on the cycle following that sample.
- Then enter W_WAIT / R_WAIT.

**W_WAIT / R_WAIT**
- Any `m_erro_addr` pulse sets `err = 01`.
- On `m_busy` falling:
  - If `err != 00`, go to RESP.
  - Else if W_WAIT and the request is a read, go to R_START.
  - Otherwise go to RESP.

**Read-phase command word**
- `m_addr = dev`, `m_rw = 1`, `m_n_byte = len`, `m_data_w = 0`.
- On each `m_valid_out`, write `m_data_out` into `rdata` byte [idx] and increment `idx`.
- Strobes arriving once `idx == len` are ignored.

**Timeout**
- A counter runs from the first cycle of *_START. It clears when the sequencer leaves *_WAIT or when `rst_n` is asserted, and is not reset on the START→WAIT transition.
- When it reaches `TIMEOUT_CYC - 1`: set `err = 10`, deassert `m_start`, go to RESP.
- The master is not aborted. IDLE keeps `req_ready` low until `m_busy` falls.

**RESP**
- `rsp_valid = 1`; `rsp_err`/`rsp_rdata` stay stable while `rsp_valid & !rsp_ready`.
- On `rsp_valid & rsp_ready`, go to IDLE.
- NACK and timeout both win over partially received data. `rsp_rdata` still returns the bytes captured.

**Simultaneous events**
- `m_erro_addr` in the same cycle as `m_busy` falling counts as NACK.
- Timeout in the same cycle as `m_busy` falling counts as success.

## Timing
**Reset values:**
- `req_ready = 0` during reset; it becomes 1 on the first cycle after release when `m_busy == 0`.
- `rsp_valid = 0`, `rsp_err = 0`, `rsp_rdata = 0`.
- `m_start = 0`, `m_rw = 0`, `m_addr = 0`, `m_data_w = 0`, `m_n_byte = 0`.

**Output registration:**
- All `m_*` outputs are registered.
- `m_*` command fields are valid on the cycle `m_start` rises and are held until the next *_START.

**Latencies:**
- Request accept to `m_start` high: 1 cycle.
- `m_busy` fall to `rsp_valid`: 1 cycle, or to `m_start` high for the read phase: 1 cycle.
- `req_ready` is low from the accept cycle until the RESP handshake completes and `m_busy == 0`. Back-to-back requests therefore need a minimum of 1 idle cycle.

**Reset mid-operation:** return to IDLE immediately and drop `m_start`. A request that was in flight gets no response.

## Configuration
- `I2C_TXN_SEQ_RETRY_EN` defined: on NACK (`err = 01`) at `m_busy` fall with `retry < MAX_RETRY`:
  - increment `retry`, clear `err` and `idx`;
  - restart from W_START, including for a NACK in the read phase.
  - `rsp_err = 01` is returned only after `MAX_RETRY + 1` failed attempts.
  - A timeout is never retried.
- Not defined: the retry counter is absent, and any NACK goes straight to RESP with `err = 01`.

## Test plan
- **Write 2 bytes:** dev=0x50, mem=0x10, len=2, wdata=0x0000BBAA.
  - Expect `m_data_w = 0x10AABB0000`, `m_n_byte = 2`, `m_rw = 0`, and exactly one master transaction.
  - Expect `rsp_err = 00`, `rsp_rdata = 0`.
- **Read 3 bytes:** dev=0x50, mem=0x20, len=3, master model returns 0x11, 0x22, 0x33.
  - Expect a write phase with `m_n_byte = 0` and `m_data_w = 0x2000000000`, then a read phase with `m_n_byte = 3`.
  - Expect `rsp_rdata = 0x00332211`, `rsp_err = 00`.
- **NACK:** model pulses `m_erro_addr` in the write phase of a read request.
  - Expect no read phase and `rsp_err = 01`.
  - With `I2C_TXN_SEQ_RETRY_EN`: expect 4 attempts before `rsp_err = 01`. A pass on the 2nd attempt returns `rsp_err = 00`.
- **Timeout:** `TIMEOUT_CYC = 50`, model holds `m_busy = 1` forever.
  - Expect `rsp_err = 10` 50 cycles after `m_start` rose.
  - Expect `req_ready` to stay 0 until `m_busy` is released.
- **Illegal length and backpressure:**
  - `req_len = 0`: expect `rsp_err = 11` with no `m_start`.
  - `rsp_ready` held low for 10 cycles: expect `rsp_*` stable throughout, and `req_ready` to stay 0.
- **Reset mid-read:** assert `rst_n` during R_WAIT.
  - Expect all outputs at their reset values next cycle and no `rsp_valid`.

Source files
------------

// File: rtl/i2c_txn_sequencer.sv
// Register-style request sequencer driving a byte-level I2C master: formats command words,
// splits reads into address-write + read phases, collects read bytes and returns a status.
// Optional build macro I2C_TXN_SEQ_RETRY_EN re-attempts address-NACKed transfers.
module i2c_txn_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 200000
`ifdef I2C_TXN_SEQ_RETRY_EN
  , parameter int unsigned MAX_RETRY = 3
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_dev,
  input  logic [7:0]  req_mem,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [39:0] m_data_w,
  output logic        m_start,
  output logic [3:0]  m_n_byte,
  input  logic [7:0]  m_data_out,
  input  logic        m_valid_out,
  input  logic        m_busy,
  input  logic        m_erro_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef I2C_TXN_SEQ_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] W_START = 3'd1;
  localparam logic [2:0] W_WAIT  = 3'd2;
  localparam logic [2:0] R_START = 3'd3;
  localparam logic [2:0] R_WAIT  = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_LEN  = 2'b11;

  logic [2:0]       state_q, state_d;
  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       mem_q, mem_d;
  logic [2:0]       len_q, len_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef I2C_TXN_SEQ_RETRY_EN
  logic [RTY_W-1:0] retry_q, retry_d;
`endif
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [6:0]       m_addr_q, m_addr_d;
  logic             m_rw_q, m_rw_d;
  logic [39:0]      m_data_w_q, m_data_w_d;
  logic             m_start_q, m_start_d;
  logic [3:0]       m_n_byte_q, m_n_byte_d;

  logic             load_w, load_r, tmo;
  logic [1:0]       err_now;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      mem_q       <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      err_q       <= ERR_OK;
      rdata_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
`ifdef I2C_TXN_SEQ_RETRY_EN
      retry_q     <= '0;
`endif
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_w_q  <= '0;
      m_start_q   <= 1'b0;
      m_n_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      mem_q       <= mem_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
`ifdef I2C_TXN_SEQ_RETRY_EN
      retry_q     <= retry_d;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_w_q  <= m_data_w_d;
      m_start_q   <= m_start_d;
      m_n_byte_q  <= m_n_byte_d;
    end
  end

  // Next-state, datapath and command-word logic
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    mem_d   = mem_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
`ifdef I2C_TXN_SEQ_RETRY_EN
    retry_d = retry_q;
`endif
    load_w  = 1'b0;
    load_r  = 1'b0;
    tmo     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    err_now = m_erro_addr ? ERR_NACK : err_q;

    // Read bytes land in order; surplus strobes beyond len are dropped
    if ((state_q == R_START || state_q == R_WAIT) && m_valid_out && (idx_q < len_q)) begin
      rdata_d[{idx_q[1:0], 3'b000} +: 8] = m_data_out;
      idx_d = idx_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          rw_d    = req_rw;
          dev_d   = req_dev;
          mem_d   = req_mem;
          len_d   = req_len;
          wdata_d = req_wdata;
          err_d   = ERR_OK;
          rdata_d = '0;
          idx_d   = '0;
`ifdef I2C_TXN_SEQ_RETRY_EN
          retry_d = '0;
`endif
          if (req_len == 3'd0 || req_len > 3'd4) begin
            err_d   = ERR_LEN;
            state_d = RESP;
          end else begin
            state_d = W_START;
            load_w  = 1'b1;
          end
        end
      end
      W_START, R_START: begin
        if (tmo) begin
          err_d   = ERR_TMO;
          state_d = RESP;
        end else if (m_busy) begin
          state_d = (state_q == W_START) ? W_WAIT : R_WAIT;
        end
      end
      W_WAIT, R_WAIT: begin
        err_d = err_now;
        // A busy fall beats a coincident timeout
        if (!m_busy) begin
          if (err_now != ERR_OK) begin
`ifdef I2C_TXN_SEQ_RETRY_EN
            if (err_now == ERR_NACK && retry_q < RTY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RTY_W'(1);
              err_d   = ERR_OK;
              idx_d   = '0;
              state_d = W_START;
              load_w  = 1'b1;
            end else begin
              state_d = RESP;
            end
`else
            state_d = RESP;
`endif
          end else if (state_q == W_WAIT && rw_q) begin
            state_d = R_START;
            load_r  = 1'b1;
          end else begin
            state_d = RESP;
          end
        end else if (tmo) begin
          err_d   = ERR_TMO;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    m_addr_d   = m_addr_q;
    m_rw_d     = m_rw_q;
    m_data_w_d = m_data_w_q;
    m_n_byte_d = m_n_byte_q;
    if (load_w) begin
      m_addr_d   = dev_d;
      m_rw_d     = 1'b0;
      m_data_w_d = rw_d ? {mem_d, 32'h0}
                        : {mem_d, wdata_d[7:0], wdata_d[15:8], wdata_d[23:16], wdata_d[31:24]};
      m_n_byte_d = rw_d ? 4'd0 : {1'b0, len_d};
    end else if (load_r) begin
      m_addr_d   = dev_q;
      m_rw_d     = 1'b1;
      m_data_w_d = '0;
      m_n_byte_d = {1'b0, len_q};
    end

    // Timeout counter spans START plus WAIT of one master transaction
    if (state_d == W_WAIT || state_d == R_WAIT ||
        (state_d == state_q && (state_q == W_START || state_q == R_START))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    req_ready_d = (state_d == IDLE) && !m_busy;
    rsp_valid_d = (state_d == RESP);
    m_start_d   = (state_d == W_START) || (state_d == R_START);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign m_addr    = m_addr_q;
  assign m_rw      = m_rw_q;
  assign m_data_w  = m_data_w_q;
  assign m_start   = m_start_q;
  assign m_n_byte  = m_n_byte_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Randomized bench for i2c_txn_sequencer: a behavioural I2C master plus a per-request
// reference model of expected master commands, status and read data.
module tb_i2c_txn_sequencer;

  localparam int unsigned TMO = 50;
`ifdef I2C_TXN_SEQ_RETRY_EN
  localparam int MAXR = 3;
`else
  localparam int MAXR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rw;
  logic [6:0]  req_dev;
  logic [7:0]  req_mem;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_rdata;
  logic [6:0]  m_addr;
  logic        m_rw, m_start;
  logic [39:0] m_data_w;
  logic [3:0]  m_n_byte;
  logic [7:0]  m_data_out;
  logic        m_valid_out, m_busy, m_erro_addr;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_dev(req_dev),
    .req_mem(req_mem), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .m_addr(m_addr), .m_rw(m_rw), .m_data_w(m_data_w), .m_start(m_start), .m_n_byte(m_n_byte),
    .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_busy(m_busy), .m_erro_addr(m_erro_addr)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [39:0] data_w;
    logic [3:0]  nb;
  } cmd_t;

  typedef struct {
    bit          nack;
    bit          nack_late;
    bit          stuck;
    int          nstr;
    logic [31:0] bytes;
  } plan_t;

  cmd_t        got_q[$];
  cmd_t        exp_q[$];
  plan_t       plan_q[$];
  plan_t       plan_arr[8];
  bit          release_busy = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [1:0]  last_err;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural master: one transaction per m_start, shaped by the next queued plan
  initial begin
    plan_t p;
    m_busy = 1'b0; m_valid_out = 1'b0; m_data_out = 8'h0; m_erro_addr = 1'b0;
    forever begin
      @(negedge clk);
      if (m_start && !m_busy && rst_n) begin
        got_q.push_back(cmd_t'({m_addr, m_rw, m_data_w, m_n_byte}));
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else p = '{nack: 1'b0, nack_late: 1'b0, stuck: 1'b0, nstr: 0, bytes: 32'h0};
        repeat ($urandom_range(0, 2)) @(negedge clk);
        m_busy = 1'b1;
        @(negedge clk);
        if (m_rw) begin
          for (int k = 0; k < p.nstr; k++) begin
            m_valid_out = 1'b1;
            m_data_out  = (k < 4) ? p.bytes[8*k +: 8] : 8'hEE;
            @(negedge clk);
            m_valid_out = 1'b0;
            @(negedge clk);
          end
        end
        if (p.stuck) begin
          wait (release_busy);
          @(negedge clk);
        end
        if (p.nack) begin
          m_erro_addr = 1'b1;
          if (p.nack_late) m_busy = 1'b0;
          @(negedge clk);
          m_erro_addr = 1'b0;
        end
        m_busy = 1'b0;
      end
    end
  end

  // Expected master commands, status and data for one request, from the transfer rules
  task automatic model(input bit rw, input logic [6:0] dev, input logic [7:0] mem,
                       input logic [2:0] len, input logic [31:0] wd,
                       output logic [1:0] err, output logic [31:0] rd, output int ntx);
    int  retry;
    bit  nack;
    rd = 32'h0; ntx = 0; retry = 0; err = 2'b00;
    if (len == 3'd0 || len > 3'd4) begin
      err = 2'b11;
      return;
    end
    forever begin
      if (rw) exp_q.push_back(cmd_t'({dev, 1'b0, mem, 32'h0, 4'd0}));
      else    exp_q.push_back(cmd_t'({dev, 1'b0, mem, wd[7:0], wd[15:8], wd[23:16], wd[31:24], 1'b0, len}));
      nack = plan_arr[ntx].nack;
      ntx++;
      if (!nack && rw) begin
        exp_q.push_back(cmd_t'({dev, 1'b1, 40'h0, 1'b0, len}));
        for (int k = 0; k < plan_arr[ntx].nstr && k < int'(len); k++)
          rd[8*k +: 8] = plan_arr[ntx].bytes[8*k +: 8];
        nack = plan_arr[ntx].nack;
        ntx++;
      end
      if (!nack) begin
        err = 2'b00;
        return;
      end
      if (retry < MAXR) begin
        retry++;
        continue;
      end
      err = 2'b01;
      return;
    end
  endtask

  task automatic plan_clean(input int len);
    for (int i = 0; i < 8; i++)
      plan_arr[i] = '{nack: 1'b0, nack_late: 1'b0, stuck: 1'b0, nstr: len, bytes: $urandom};
  endtask

  task automatic plan_random(input int len);
    for (int i = 0; i < 8; i++) begin
      plan_arr[i].nack      = ($urandom_range(0, 3) == 0);
      plan_arr[i].nack_late = 1'($urandom_range(0, 1));
      plan_arr[i].stuck     = 1'b0;
      plan_arr[i].bytes     = $urandom;
      plan_arr[i].nstr      = plan_arr[i].nack ? int'($urandom_range(0, len)) : len + int'($urandom_range(0, 1));
    end
  endtask

  task automatic run_req(input bit rw, input logic [6:0] dev, input logic [7:0] mem,
                         input logic [2:0] len, input logic [31:0] wd, input int bp);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int          ntx, cyc;
    exp_q.delete(); got_q.delete(); plan_q.delete();
    model(rw, dev, mem, len, wd, e_err, e_rd, ntx);
    for (int i = 0; i < ntx; i++) plan_q.push_back(plan_arr[i]);
    cyc = 0;
    while (!req_ready && cyc < 200) begin @(negedge clk); cyc++; end
    if (!req_ready) begin check("req_ready_wait", req_ready, 1); return; end
    req_rw = rw; req_dev = dev; req_mem = mem; req_len = len; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("start_latency", m_start, (exp_q.size() > 0));
    cyc = 0;
    while (!rsp_valid && cyc < 500) begin @(negedge clk); cyc++; end
    check("rsp_valid_wait", rsp_valid, 1);
    if (!rsp_valid) return;
    last_err = rsp_err; last_rdata = rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_err", rsp_err, last_err);
      check("hold_rdata", rsp_rdata, last_rdata);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("rsp_err", last_err, e_err);
    check("rsp_rdata", last_rdata, e_rd);
    check("n_txn", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("txn_cmd", got_q[i], exp_q[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc, r;
    bit          seen;
    logic [2:0]  len;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_mem = '0;
    req_len = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("rst_m_cmd", {m_start, m_rw, m_addr, m_data_w, m_n_byte}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);

    // Two-byte write
    plan_clean(0);
    run_req(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BBAA, 0);
    check("wr2_data_w", got_q.size() > 0 ? got_q[0].data_w : 40'h0, 40'h10AABB0000);
    check("wr2_rdata", last_rdata, 32'h0);

    // Three-byte random read
    plan_clean(3);
    plan_arr[1].bytes = 32'h00332211;
    run_req(1'b1, 7'h50, 8'h20, 3'd3, 32'hDEADBEEF, 2);
    check("rd3_rdata", last_rdata, 32'h00332211);
    check("rd3_ntx", got_q.size(), 2);

    // Address NACK in the write phase of a read
    plan_clean(2);
    for (int i = 0; i < 8; i++) plan_arr[i].nack = 1'b1;
    run_req(1'b1, 7'h51, 8'h30, 3'd2, 32'h0, 0);
    check("nack_err", last_err, 2'b01);
    check("nack_ntx", got_q.size(), MAXR + 1);
`ifdef I2C_TXN_SEQ_RETRY_EN
    plan_clean(2);
    plan_arr[0].nack = 1'b1;
    run_req(1'b1, 7'h51, 8'h30, 3'd2, 32'h0, 0);
    check("retry_pass_err", last_err, 2'b00);
    check("retry_pass_ntx", got_q.size(), 3);
`endif

    // Illegal lengths with response backpressure
    plan_clean(0);
    run_req(1'b0, 7'h12, 8'h34, 3'd0, 32'h12345678, 10);
    check("len0_err", last_err, 2'b11);
    run_req(1'b1, 7'h12, 8'h34, 3'd5, 32'h0, 1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      len = (r == 0) ? 3'd0 : (r == 1) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      plan_random(int'(len));
      run_req(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), len, $urandom,
              int'($urandom_range(0, 3)));
    end

    // Timeout with master stuck busy
    plan_clean(0);
    plan_arr[0].stuck = 1'b1;
    got_q.delete(); plan_q.delete();
    plan_q.push_back(plan_arr[0]);
    cyc = 0;
    while (!req_ready && cyc < 200) begin @(negedge clk); cyc++; end
    req_rw = 1'b0; req_dev = 7'h33; req_mem = 8'h44; req_len = 3'd1; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("tmo_start", m_start, 1);
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin @(negedge clk); cyc++; end
    check("tmo_latency", cyc, TMO);
    check("tmo_err", rsp_err, 2'b10);
    check("tmo_m_start", m_start, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("tmo_ready_low", req_ready, 0);
    end
    release_busy = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 6) begin @(negedge clk); cyc++; end
    check("tmo_ready_back", req_ready, 1);
    release_busy = 1'b0;

    // Reset while the read phase is in flight
    plan_clean(4);
    plan_arr[1].nstr  = 2;
    plan_arr[1].stuck = 1'b1;
    got_q.delete(); plan_q.delete();
    plan_q.push_back(plan_arr[0]);
    plan_q.push_back(plan_arr[1]);
    req_rw = 1'b1; req_dev = 7'h2A; req_mem = 8'h77; req_len = 3'd4; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!(got_q.size() == 2 && m_busy) && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (6) @(negedge clk);
    check("pre_rst_rw", m_rw, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("mid_rst_m_cmd", {m_start, m_rw, m_addr, m_data_w, m_n_byte}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    release_busy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    release_busy = 1'b0;
    check("rst_no_rsp", seen, 0);
    check("rst_ready_after", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
